baud_gen: RTL and testbench
===========================

# baud_gen

Parametrised UART baud-rate generator replacing the fixed single-rate counter. Divides the system clock by a runtime-programmable integer (optionally fractional) divisor to produce an oversample tick, then derives bit-rate and mid-bit ticks from it. Feeds the UART TX shifter (`bit_tick`) and RX sampler (`os_tick`, `mid_tick`, `resync` on start-bit edge).

## Interface
- `DIV_W`, 16, width of the integer divisor
- `OS_RATE`, 16, oversample ticks per bit; power of two, 4..64
- `RESET_DIV`, 54, divisor after reset (100 MHz / (115200·16) ≈ 54)
- `FRAC_W`, 4, fractional divisor width; used only with `BAUD_FRAC_EN`

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  run enable
- `div`  in  DIV_W  integer clocks per oversample tick
- `div_frac`  in  FRAC_W  fractional part, in units of 2^-FRAC_W (port exists only with `BAUD_FRAC_EN`)
- `div_wr`  in  1  one-cycle strobe; captures `div` and `div_frac`
- `resync`  in  1  restarts both prescaler and oversample phase
- `os_tick`  out  1  one-cycle pulse at oversample rate
- `mid_tick`  out  1  one-cycle pulse at mid-bit
- `bit_tick`  out  1  one-cycle pulse at bit rate
- `div_err`  out  1  sticky illegal-divisor flag

## Operation
- Reset: all outputs 0, prescaler count 0, oversample count 0, `div_active` = RESET_DIV, no pending write, fractional accumulator 0.
- `div_wr` with `div` ≥ 2: value goes to a shadow register and `div_err` clears. With `div` < 2: write ignored, `div_err` set. It stays set until the next legal write.
- The shadow register moves to `div_active` at the next prescaler wrap, or at once if `en`=0 or `resync`=1. The rate never changes mid-period.
- Prescaler: while `en`=1, counts 0..P-1, where P = `div_active` (plus 1 when the fractional carry is set). `os_tick` pulses on the wrap.
- Oversample counter: 0..OS_RATE-1, advances on each `os_tick`.
- `mid_tick` accompanies the `os_tick` that moves the counter from OS_RATE/2-1 to OS_RATE/2.
- `bit_tick` accompanies the `os_tick` that wraps the counter from OS_RATE-1 to 0.
- `en`=0: both counters and the accumulator clear synchronously, all ticks 0. A pending write is applied.
- `resync`=1: same clearing as `en`=0. Any tick in that cycle is suppressed. `resync` has priority over counting.
- Simultaneous `div_wr` and `resync`: the new legal divisor is applied directly to `div_active`.

## Timing
- All ticks are registered, single-cycle, mutually aligned: `mid_tick`/`bit_tick` never fire without `os_tick`.
- After `en` rises or `resync` deasserts, the first `os_tick` is high in the cycle after the P-th rising edge with counting enabled.
- `os_tick` period: P clocks. `mid_tick` comes OS_RATE/2 os periods after restart, then every OS_RATE. `bit_tick` comes OS_RATE os periods after restart, then every OS_RATE.
- A reset assertion mid-operation clears everything asynchronously. The first tick after deassertion follows the rule above, using RESET_DIV.

## Configuration
- `BAUD_FRAC_EN` defined:
  - `div_frac` port present; FRAC_W-bit accumulator adds `div_frac` at each prescaler wrap.
  - A carry-out lengthens the next oversample period by one clock.
  - Long-run average period = `div` + `div_frac`/2^FRAC_W.
- Undefined: no `div_frac` port and no accumulator. Every period is exactly `div_active` clocks.

## Structure
- Package `baud_pkg`: default OS_RATE, RESET_DIV, FRAC_W, DIV_W, and the clock-frequency constant (100 MHz) used to compute standard divisors.
- Sub-module `baud_prescaler`: integer/fractional clock-enable divider with shadow-divisor handling. It outputs the raw oversample strobe.
- `baud_gen` adds the oversample counter, tick decode, `resync` and `div_err`.

## Test plan
- Reset release, `en`=1, no write → `os_tick` every 54 clocks, `bit_tick` every 864, `mid_tick` 432 clocks after start.
- `div_wr` with `div`=4 while idle, then `en`=1 → `os_tick` every 4 clocks, `mid_tick` at clock 32, `bit_tick` at 64, 128, …
- `div_wr` with `div`=1 → `div_err`=1, rate unchanged. Then `div`=8 → `div_err`=0, new rate takes effect at the next prescaler wrap.
- `resync` pulse mid-bit with `div`=4 → no tick that cycle; next `mid_tick` 32 clocks and next `bit_tick` 64 clocks after deassertion.
- `rst_n` pulled low mid-count → all outputs 0 immediately; after release the divisor is back to 54.
- With `BAUD_FRAC_EN`, `div`=4, `div_frac`=8 (FRAC_W=4) → os periods alternate 4/5 clocks; 32 os ticks take exactly 144 clocks.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared defaults for the UART baud-rate generator, plus the helper that turns
// a baud rate into an integer prescaler divisor for the 100 MHz system clock.
package baud_pkg;
  localparam int BAUD_CLK_HZ       = 100_000_000;
  localparam int BAUD_DIV_W        = 16;
  localparam int BAUD_OS_RATE      = 16;
  localparam int BAUD_FRAC_W       = 4;
  localparam int BAUD_DEFAULT_RATE = 115_200;

  function automatic int baud_divisor(input int baud, input int os_rate);
    return BAUD_CLK_HZ / (baud * os_rate);
  endfunction

  localparam int BAUD_RESET_DIV = baud_divisor(BAUD_DEFAULT_RATE, BAUD_OS_RATE);
endpackage

// File: rtl/baud_prescaler.sv
// Clock-enable divider producing the raw oversample strobe, with a shadow divisor
// that only takes effect on a period boundary. Fractional accumulator under BAUD_FRAC_EN.
module baud_prescaler #(
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 54
`ifdef BAUD_FRAC_EN
  ,
  parameter int FRAC_W    = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div,
`ifdef BAUD_FRAC_EN
  input  logic [FRAC_W-1:0] div_frac,
`endif
  output logic             os_strobe
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_active;
  logic [DIV_W-1:0] div_shadow;
  logic             pending;
  logic             carry;
  logic             last;
  logic             apply_shadow;

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc;
  logic [FRAC_W-1:0] frac_active;
  logic [FRAC_W-1:0] frac_shadow;
  logic [FRAC_W:0]   acc_sum;

  // The carry of the add performed at the end of this period stretches it by one clock.
  assign acc_sum = {1'b0, acc} + {1'b0, frac_active};
  assign carry   = acc_sum[FRAC_W];
`else
  assign carry = 1'b0;
`endif

  assign last         = carry ? (cnt == div_active) : (cnt == div_active - 1'b1);
  assign os_strobe    = run & last;
  assign apply_shadow = pending & (~run | last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_active  <= DIV_W'(RESET_DIV);
      div_shadow  <= DIV_W'(RESET_DIV);
      pending     <= 1'b0;
`ifdef BAUD_FRAC_EN
      frac_active <= '0;
      frac_shadow <= '0;
`endif
    end else begin
      if (apply_shadow) begin
        div_active  <= div_shadow;
`ifdef BAUD_FRAC_EN
        frac_active <= frac_shadow;
`endif
      end
      if (div_wr && !run) begin
        div_active  <= div;
        pending     <= 1'b0;
`ifdef BAUD_FRAC_EN
        frac_active <= div_frac;
`endif
      end else if (div_wr) begin
        div_shadow  <= div;
        pending     <= 1'b1;
`ifdef BAUD_FRAC_EN
        frac_shadow <= div_frac;
`endif
      end else if (apply_shadow) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef BAUD_FRAC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (!run) begin
      acc <= '0;
    end else if (last) begin
      acc <= acc_sum[FRAC_W-1:0];
    end
  end
`endif

endmodule

// File: rtl/baud_gen.sv
// UART baud-rate generator: prescaler strobe feeds an oversample counter that decodes
// registered os/mid/bit ticks. Define BAUD_FRAC_EN for the fractional divisor port.
module baud_gen
  import baud_pkg::*;
#(
  parameter int DIV_W     = BAUD_DIV_W,
  parameter int OS_RATE   = BAUD_OS_RATE,
  parameter int RESET_DIV = BAUD_RESET_DIV,
  parameter int FRAC_W    = BAUD_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
`ifdef BAUD_FRAC_EN
  input  logic [FRAC_W-1:0] div_frac,
`endif
  input  logic              div_wr,
  input  logic              resync,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              div_err
);

  localparam int OS_W = $clog2(OS_RATE);

  logic            run;
  logic            div_ok;
  logic            os_strobe;
  logic [OS_W-1:0] os_cnt;

  // resync behaves exactly like a one-cycle disable, so both fold into one run qualifier.
  assign run    = en & ~resync;
  assign div_ok = div >= DIV_W'(2);

  baud_prescaler #(
    .DIV_W     (DIV_W),
    .RESET_DIV (RESET_DIV)
`ifdef BAUD_FRAC_EN
    ,
    .FRAC_W    (FRAC_W)
`endif
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .div_wr    (div_wr & div_ok),
    .div       (div),
`ifdef BAUD_FRAC_EN
    .div_frac  (div_frac),
`endif
    .os_strobe (os_strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      os_tick  <= os_strobe;
      mid_tick <= os_strobe && (os_cnt == OS_W'(OS_RATE / 2 - 1));
      bit_tick <= os_strobe && (os_cnt == OS_W'(OS_RATE - 1));
      if (!run) begin
        os_cnt <= '0;
      end else if (os_strobe) begin
        os_cnt <= os_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_err <= 1'b0;
    end else if (div_wr) begin
      div_err <= ~div_ok;
    end
  end

endmodule

// File: tb/tb_baud_gen.sv
// Bench for baud_gen: expected tick edges are computed arithmetically from the divisor
// rules and queued; a monitor pops and compares each tick the DUT presents.
module tb_baud_gen;
  localparam int DIV_W   = 16;
  localparam int OS_RATE = 16;
  localparam int FRAC_W  = 4;
  localparam int unsigned NO_LIMIT = 32'hFFFF_FFFF;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             en     = 1'b0;
  logic             div_wr = 1'b0;
  logic             resync = 1'b0;
  logic [DIV_W-1:0] div    = '0;
`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] div_frac = '0;
`endif
  logic os_tick, mid_tick, bit_tick, div_err;

  typedef struct {
    int unsigned cyc;
    bit          mid;
    bit          bt;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  baud_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div      (div),
`ifdef BAUD_FRAC_EN
    .div_frac (div_frac),
`endif
    .div_wr   (div_wr),
    .resync   (resync),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick),
    .div_err  (div_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Tick k of a run lands on edge start-1 + sum of periods; period = divisor plus the
  // fractional carries, and the divisor switches after the first wrap past edge w.
  function automatic int unsigned push_run(input int unsigned e, input int p_old,
                                           input int p_new, input int unsigned w,
                                           input int frac, input int n,
                                           input int unsigned limit);
    int unsigned t = e - 1;
    int          p = p_old;
    bit          applied = 1'b0;
    for (int k = 1; k <= n; k++) begin
      t += p + (((k * frac) >> FRAC_W) - (((k - 1) * frac) >> FRAC_W));
      if (t >= limit) break;
      q.push_back('{cyc: t, mid: (k % OS_RATE) == OS_RATE / 2, bt: (k % OS_RATE) == 0});
      if (!applied && t > w) begin
        p = p_new;
        applied = 1'b1;
      end
    end
    return q.size() > 0 ? q[$].cyc : e - 1;
  endfunction

  always @(negedge clk) begin
    if (os_tick || mid_tick || bit_tick) begin
      if (mid_tick || bit_tick) chk("os_with_tick", os_tick, 1'b1);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tick at cycle %0d os=%0b mid=%0b bit=%0b required none",
                 cyc, os_tick, mid_tick, bit_tick);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("tick_cycle", cyc, e.cyc);
        chk("mid_tick", mid_tick, e.mid);
        chk("bit_tick", bit_tick, e.bt);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) step();
  endtask

  task automatic idle_write(input int d, input int f);
    step();
    div    = DIV_W'(d);
`ifdef BAUD_FRAC_EN
    div_frac = FRAC_W'(f);
`endif
    div_wr = 1'b1;
    step();
    div_wr = 1'b0;
  endtask

  task automatic seg_end();
    step();
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  task automatic run_plain(input int d, input int n, input int frac);
    int unsigned e, last;
    step();
    en   = 1'b1;
    e    = cyc + 1;
    last = push_run(e, d, d, 0, frac, n, NO_LIMIT);
    wait_until(last);
    en = 1'b0;
    seg_end();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e, last, w1, w2, r, r2;
    int d, n;

    repeat (3) step();
    chk("reset_os_tick", os_tick, 0);
    chk("reset_mid_tick", mid_tick, 0);
    chk("reset_bit_tick", bit_tick, 0);
    chk("reset_div_err", div_err, 0);
    rst_n = 1'b1;

    run_plain(54, 34, 0);

    idle_write(4, 0);
    run_plain(4, 40, 0);

    for (int i = 0; i < 4; i++) begin
      d = int'($urandom_range(2, 9));
      n = int'($urandom_range(8, 40));
      idle_write(d, 0);
      run_plain(d, n, 0);
    end

    // Illegal write while running leaves the rate alone; legal one lands on the next wrap.
    idle_write(4, 0);
    step();
    en   = 1'b1;
    e    = cyc + 1;
    w1   = e + $urandom_range(5, 20);
    w2   = w1 + $urandom_range(3, 30);
    last = push_run(e, 4, 8, w2, 0, 40, NO_LIMIT);
    wait_until(w1 - 1);
    div    = DIV_W'($urandom_range(0, 1));
    div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    chk("div_err_set", div_err, 1);
    wait_until(w2 - 1);
    div    = 8;
    div_wr = 1'b1;
    step();
    div_wr = 1'b0;
    chk("div_err_clear", div_err, 0);
    wait_until(last);
    en = 1'b0;
    seg_end();

    // resync mid-bit, then resync together with a new divisor.
    idle_write(4, 0);
    step();
    en = 1'b1;
    e  = cyc + 1;
    r  = e - 1 + 4 * $urandom_range(9, 13) + $urandom_range(0, 3);
    void'(push_run(e, 4, 4, 0, 0, 1000, r));
    wait_until(r - 1);
    resync = 1'b1;
    step();
    resync = 1'b0;
    chk("resync_queue_drained", q.size(), 0);
    last = push_run(r + 1, 4, 4, 0, 0, 16, NO_LIMIT);
    wait_until(last);
    r2 = last + 2;
    wait_until(r2 - 1);
    resync = 1'b1;
    div    = 6;
    div_wr = 1'b1;
    step();
    resync = 1'b0;
    div_wr = 1'b0;
    last = push_run(r2 + 1, 6, 6, 0, 0, 20, NO_LIMIT);
    wait_until(last);
    en = 1'b0;
    seg_end();

    // Reset in the cycle a bit_tick is showing; divisor must fall back to 54.
    idle_write(4, 0);
    idle_write(1, 0);
    chk("div_err_idle", div_err, 1);
    step();
    en   = 1'b1;
    e    = cyc + 1;
    last = push_run(e, 4, 4, 0, 0, 16, NO_LIMIT);
    wait_until(last);
    rst_n = 1'b0;
    #1;
    chk("async_rst_os_tick", os_tick, 0);
    chk("async_rst_mid_tick", mid_tick, 0);
    chk("async_rst_bit_tick", bit_tick, 0);
    chk("async_rst_div_err", div_err, 0);
    chk("rst_queue_drained", q.size(), 0);
    step();
    rst_n = 1'b1;
    e     = cyc + 1;
    last  = push_run(e, 54, 54, 0, 0, 3, NO_LIMIT);
    wait_until(last);
    en = 1'b0;
    seg_end();

`ifdef BAUD_FRAC_EN
    idle_write(4, 8);
    run_plain(4, 32, 8);
    d = int'($urandom_range(2, 7));
    n = int'($urandom_range(1, 15));
    idle_write(d, n);
    run_plain(d, 40, n);
`endif

    chk("final_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
